backward_registered: RTL and testbench

- Ready/valid register slice that breaks the combinational `ready` path: the upstream `m_ready` is driven straight from a flop.
- Valid and data pass through combinationally, with a one-entry skid register that absorbs the beat in flight when downstream stalls.
- Pairs with the team's forward-registered slice, which registers the forward (`valid`/`data`) path.
- Also carries saturating transfer and stall counters for bring-up visibility.

---
 rtl/backward_registered.sv | 116 +++++++++++
 tb/tb_backward_registered.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/backward_registered.sv
// backward_registered: ready/valid register slice that registers the backward
// (ready) path. m_ready comes straight from a flop. valid/data pass through
// combinationally, and a one-entry skid register catches the beat in flight
// when downstream stalls. Saturating transfer/stall counters aid bring-up.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   m_valid    upstream beat valid
//   m_data     upstream payload [WIDTH]
//   m_ready    upstream ready, direct flop output
//   s_valid    downstream beat valid
//   s_data     downstream payload [WIDTH]
//   s_ready    downstream ready
//   cnt_clr    synchronous clear of both counters
//   xfer_cnt   saturating count of downstream transfers [CNT_WIDTH]
//   stall_cnt  saturating count of s_valid & ~s_ready cycles [CNT_WIDTH]
module backward_registered #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m_valid,
  input  logic [WIDTH-1:0]     m_data,
  output logic                 m_ready,
  output logic                 s_valid,
  output logic [WIDTH-1:0]     s_data,
  input  logic                 s_ready,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] xfer_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // State encodes skid_valid: FULL means the skid holds an undelivered beat.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] skid_data;
  logic             skid_load;
  logic             up_xfer;
  logic             dn_xfer;
  logic             stall;

  // State, skid payload and the registered upstream ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      skid_data <= '0;
      m_ready   <= 1'b0;
    end else begin
      state   <= state_next;
      // Ready depends only on where the skid will be, never on s_ready directly.
      m_ready <= (state_next == EMPTY);
      if (skid_load) begin
        skid_data <= m_data;
      end
    end
  end

  // Next-state and datapath select.
  always_comb begin
    state_next = state;
    skid_load  = 1'b0;
    s_valid    = 1'b0;
    s_data     = m_data;
    up_xfer    = m_valid & m_ready;
    case (state)
      EMPTY: begin
        s_valid = up_xfer;
        s_data  = m_data;
        // Beat accepted but not taken downstream: park it in the skid.
        if (up_xfer && !s_ready) begin
          state_next = FULL;
          skid_load  = 1'b1;
        end
      end
      FULL: begin
        // m_ready is low here, so no new beat can arrive while draining.
        s_valid = 1'b1;
        s_data  = skid_data;
        if (s_ready) begin
          state_next = EMPTY;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  assign dn_xfer = s_valid & s_ready;
  assign stall   = s_valid & ~s_ready;

  // Saturating bring-up counters; clear takes priority over increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (dn_xfer && (xfer_cnt != CNT_MAX)) begin
        xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
      end
      if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_backward_registered.sv
// tb_backward_registered: directed and scoreboarded checks of the
// backward-registered slice, plus a narrow-counter instance for saturation.
module tb_backward_registered;

  logic        clk;
  logic        rst;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        cnt_clr;
  logic [15:0] xfer_cnt;
  logic [15:0] stall_cnt;

  logic        m_valid2;
  logic [7:0]  m_data2;
  logic        m_ready2;
  logic        s_valid2;
  logic [7:0]  s_data2;
  logic        s_ready2;
  logic        cnt_clr2;
  logic [3:0]  xfer_cnt2;
  logic [3:0]  stall_cnt2;

  int n_checks;
  int n_errors;

  backward_registered #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt)
  );

  backward_registered #(.WIDTH(8), .CNT_WIDTH(4)) dut_narrow (
    .clk(clk), .rst(rst),
    .m_valid(m_valid2), .m_data(m_data2), .m_ready(m_ready2),
    .s_valid(s_valid2), .s_data(s_data2), .s_ready(s_ready2),
    .cnt_clr(cnt_clr2), .xfer_cnt(xfer_cnt2), .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] next_data;
  logic [7:0] exp_data;
  int         sent;
  int         delivered;
  int         cycles;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       seen_3c;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; m_valid = 1'b0; m_data = 8'h00; s_ready = 1'b0; cnt_clr = 1'b0;
    m_valid2 = 1'b0; m_data2 = 8'h00; s_ready2 = 1'b0; cnt_clr2 = 1'b0;

    // Reset then idle.
    repeat (3) cyc();
    check("rst_m_ready", 32'(m_ready), 32'd0);
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_xfer", 32'(xfer_cnt), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    cyc();
    check("post_rst_m_ready", 32'(m_ready), 32'd1);

    // Streaming, zero latency.
    s_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      m_valid = 1'b1;
      m_data  = 8'(i);
      #1;
      check("stream_valid", 32'(s_valid), 32'd1);
      check("stream_data", 32'(s_data), 32'(i));
      check("stream_m_ready", 32'(m_ready), 32'd1);
      cyc();
    end
    m_valid = 1'b0;
    check("stream_xfer", 32'(xfer_cnt), 32'd16);
    check("stream_stall", 32'(stall_cnt), 32'd0);

    // Single stall.
    m_valid = 1'b1; m_data = 8'hA5; s_ready = 1'b0;
    #1;
    check("stall_pass_valid", 32'(s_valid), 32'd1);
    check("stall_pass_data", 32'(s_data), 32'hA5);
    cyc();
    m_valid = 1'b0; m_data = 8'h00;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("stall_m_ready", 32'(m_ready), 32'd0);
      check("stall_valid", 32'(s_valid), 32'd1);
      check("stall_data", 32'(s_data), 32'hA5);
      cyc();
    end
    check("stall_cnt5", 32'(stall_cnt), 32'd5);
    s_ready = 1'b1;
    #1;
    check("drain_valid", 32'(s_valid), 32'd1);
    check("drain_data", 32'(s_data), 32'hA5);
    check("drain_m_ready", 32'(m_ready), 32'd0);
    cyc();
    check("drain_after_m_ready", 32'(m_ready), 32'd1);
    check("drain_after_valid", 32'(s_valid), 32'd0);
    check("drain_xfer", 32'(xfer_cnt), 32'd17);
    check("drain_stall", 32'(stall_cnt), 32'd5);

    // Clear the counters with no traffic.
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    check("clr_xfer", 32'(xfer_cnt), 32'd0);
    check("clr_stall", 32'(stall_cnt), 32'd0);

    // Random backpressure with an in-order scoreboard.
    sent = 0; delivered = 0; cycles = 0; next_data = 8'h00;
    prev_stall = 1'b0; prev_data = 8'h00;
    while (delivered < 1000 && cycles < 20000) begin
      m_valid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      m_data  = next_data;
      s_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        check("hold_valid", 32'(s_valid), 32'd1);
        check("hold_data", 32'(s_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        q.push_back(next_data);
        next_data = next_data + 8'd1;
        sent++;
      end
      if (s_valid && s_ready) begin
        if (q.size() == 0) begin
          check("rand_spurious", 32'(s_valid), 32'd0);
        end else begin
          exp_data = q.pop_front();
          check("rand_data", 32'(s_data), 32'(exp_data));
        end
        delivered++;
      end
      if (q.size() > 1) begin
        check("rand_occupancy", 32'(q.size()), 32'd1);
      end
      prev_stall = s_valid & ~s_ready;
      prev_data  = s_data;
      @(posedge clk);
      #1;
      cycles++;
    end
    m_valid = 1'b0;
    check("rand_delivered", 32'(delivered), 32'd1000);
    check("rand_queue_empty", 32'(q.size()), 32'd0);
    check("rand_xfer", 32'(xfer_cnt), 32'd1000);

    // Reset mid-operation discards the skid beat.
    s_ready = 1'b1;
    repeat (2) cyc();
    m_valid = 1'b1; m_data = 8'h3C; s_ready = 1'b0;
    cyc();
    m_valid = 1'b0; m_data = 8'h00;
    #1;
    check("midrst_full_valid", 32'(s_valid), 32'd1);
    check("midrst_full_data", 32'(s_data), 32'h3C);
    rst = 1'b1;
    cyc();
    check("midrst_s_valid", 32'(s_valid), 32'd0);
    check("midrst_m_ready", 32'(m_ready), 32'd0);
    rst = 1'b0; s_ready = 1'b1;
    seen_3c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (s_valid) seen_3c = 1'b1;
    end
    check("midrst_no_3c", 32'(seen_3c), 32'd0);
    check("midrst_m_ready_back", 32'(m_ready), 32'd1);

    // Counter saturation on the 4-bit instance.
    m_valid2 = 1'b1; s_ready2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      m_data2 = 8'(i);
      cyc();
      if (i == 14) check("sat_at_15", 32'(xfer_cnt2), 32'd15);
    end
    check("sat_held", 32'(xfer_cnt2), 32'd15);
    check("sat_stall", 32'(stall_cnt2), 32'd0);
    cnt_clr2 = 1'b1;
    cyc();
    check("sat_clr_wins", 32'(xfer_cnt2), 32'd0);
    cnt_clr2 = 1'b0;
    cyc();
    check("sat_after_clr", 32'(xfer_cnt2), 32'd1);
    m_valid2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
